encoder_4_to_2_sync: RTL and testbench
======================================

Name: encoder_4_to_2_sync

Overview:
- Registered 4-to-2 request encoder, the inverse of the 2-to-4 decoder.
- Latches single-cycle request strobes on 4 lines into a pending set.
- Emits one 2-bit index per granted request on a valid/ready output handshake, then clears that request.
- Sits between decoded select/interrupt-style lines and a consumer that handles one index at a time.

Parameters:
- PRIORITY_HIGH, default 1, 1 = bit 3 has highest fixed priority; 0 = bit 0 has highest priority.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- ena  input  1  enable for request capture; when 0, in is ignored
- in  input  4  request strobes, multi-hot allowed, sampled each cycle when ena=1
- out  output  2  encoded index of granted request, valid when out_valid=1
- out_valid  output  1  out holds a granted index
- out_ready  input  1  consumer accepts out this cycle
- busy  output  1  (pending != 0) | out_valid

Behaviour:
- Reset (rst=1 at edge): pending=4'b0000, out=2'b00, out_valid=0, state=IDLE; RR pointer (if enabled) = highest-priority bit. Reset overrides every other action, including a mid-handshake transfer; requests presented in a reset cycle are dropped.
- Capture: pending_next = (pending & ~load_mask) | (in & {4{ena}}).
  - load_mask is the one-hot of the index loaded into out at this edge (0 if none).
  - Set wins over clear: a new request on the bit being loaded this edge stays pending.
  - A request on an already-pending bit merges; there is no counting.
- Selection: sel = index of highest-priority set bit of registered pending, per PRIORITY_HIGH or the RR rule. Same-cycle in is never visible to selection.
- load = (state==IDLE | out_ready) & (pending != 0).
- FSM:
  - IDLE (out_valid=0): if pending!=0, load out=sel, go VALID; else stay IDLE.
  - VALID (out_valid=1): out is held stable while out_ready=0.
  - VALID with out_ready=1: if pending!=0, load next sel and stay VALID (back-to-back, one index per cycle); else go IDLE, out_valid=0, out keeps its last value.
- Latency: strobe sampled at edge k enters pending; out_valid=1 after edge k+1, i.e. 2 cycles from strobe to valid on an idle block.
- Throughput: 1 index per cycle while out_ready=1.
- A request on the bit currently held in out (not yet accepted) re-pends and is re-granted later.
- ena=0 only blocks capture. Pending drain and the handshake continue.
- busy is combinational from registered state.

Optional Feature:
- Macro: ENCODER_ROUND_ROBIN_EN.
- Defined: rotating priority. A 2-bit pointer rp resets to the highest-priority bit.
  - Selection searches from rp in the PRIORITY_HIGH direction (descending if 1, ascending if 0), with wrap-around.
  - On each load, rp moves one position past sel in the search direction.
  - With pending=1111 continuously re-requested and PRIORITY_HIGH=1, grants are 3,2,1,0,3,...
- Undefined: fixed priority only; no pointer register is synthesized.

Test Plan:
- Reset then idle, in=0 for 5 cycles -> out_valid=0, out=00, busy=0 throughout.
- PRIORITY_HIGH=1, ena=1, in=4'b0100 for 1 cycle, out_ready=1 -> out_valid=1 with out=10 exactly 2 edges after the strobe for 1 cycle, then out_valid=0, busy=0.
- in=4'b1011 for 1 cycle, out_ready=1 -> out sequence 11,01,00 on consecutive cycles, then IDLE. With PRIORITY_HIGH=0 the sequence is 00,01,11.
- in=4'b0011 strobe, out_ready=0 for 4 cycles -> out=01 held stable with out_valid=1; on out_ready=1, grants 01 then 00; meanwhile ena=0 with in=1111 -> no extra grants.
- Set/clear collision: while out=01 is being loaded, in=4'b0010 the same cycle -> bit 1 stays pending and index 01 is granted twice in total.
- rst=1 asserted while out_valid=1, pending=1100 -> next cycle out_valid=0, busy=0, out=00; no later grants. With ENCODER_ROUND_ROBIN_EN defined, in=1111 every cycle gives 3,2,1,0,3.

Source files
------------

// File: rtl/encoder_4_to_2_sync.sv
// Registered 4-to-2 request encoder: captures request strobes into a pending set
// and grants one index per valid/ready handshake. Optional ENCODER_ROUND_ROBIN_EN.
module encoder_4_to_2_sync #(
   parameter int PRIORITY_HIGH = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [3:0] in,
   output logic [1:0] out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy
);

   typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

   state_t     r_state;
   logic [3:0] r_pending;
   logic [1:0] r_out;
   logic [1:0] w_sel;
   logic       w_load;
   logic [3:0] w_load_mask;

`ifdef ENCODER_ROUND_ROBIN_EN
   logic [1:0] r_rp;
   logic [1:0] w_idx;

   // Scan farthest-to-nearest from r_rp so the nearest pending bit is written last.
   always_comb begin
      w_sel = r_rp;
      w_idx = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         w_idx = (PRIORITY_HIGH != 0) ? 2'(r_rp - 2'(3 - k)) : 2'(r_rp + 2'(3 - k));
         if (r_pending[w_idx]) w_sel = w_idx;
      end
   end
`else
   always_comb begin
      w_sel = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (PRIORITY_HIGH != 0) begin
            if (r_pending[i]) w_sel = 2'(i);
         end else begin
            if (r_pending[3 - i]) w_sel = 2'(3 - i);
         end
      end
   end
`endif

   assign w_load      = ((r_state == IDLE) | out_ready) & (r_pending != 4'b0000);
   assign w_load_mask = w_load ? (4'b0001 << w_sel) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_out     <= '0;
`ifdef ENCODER_ROUND_ROBIN_EN
         r_rp      <= (PRIORITY_HIGH != 0) ? 2'd3 : 2'd0;
`endif
      end else begin
         r_pending <= (r_pending & ~w_load_mask) | (in & {4{ena}});
         if (w_load) begin
            r_out   <= w_sel;
            r_state <= VALID;
`ifdef ENCODER_ROUND_ROBIN_EN
            r_rp    <= (PRIORITY_HIGH != 0) ? 2'(w_sel - 2'd1) : 2'(w_sel + 2'd1);
`endif
         end else if ((r_state == VALID) && out_ready) begin
            r_state <= IDLE;
         end
      end
   end

   assign out       = r_out;
   assign out_valid = (r_state == VALID);
   assign busy      = (r_pending != 4'b0000) | (r_state == VALID);

endmodule

// File: tb/tb_encoder_4_to_2_sync.sv
// Self-checking bench for encoder_4_to_2_sync: one instance per priority direction,
// directed scenarios plus randomized traffic against a behavioural model.
module tb_encoder_4_to_2_sync;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic [3:0] in_ = '0;
   logic       out_ready = 1'b0;

   logic [1:0] dout [2];
   logic       dval [2];
   logic       dbusy[2];

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] mp[2];
   logic [1:0] mo[2];
   logic       mv[2];
   logic [1:0] mr[2];

   int gq0[$];
   int gq1[$];

   always #5 clk = ~clk;

   encoder_4_to_2_sync #(.PRIORITY_HIGH(1)) u_hi (
      .clk(clk), .rst(rst), .ena(ena), .in(in_), .out(dout[0]),
      .out_valid(dval[0]), .out_ready(out_ready), .busy(dbusy[0]));

   encoder_4_to_2_sync #(.PRIORITY_HIGH(0)) u_lo (
      .clk(clk), .rst(rst), .ena(ena), .in(in_), .out(dout[1]),
      .out_valid(dval[1]), .out_ready(out_ready), .busy(dbusy[1]));

   // Grant choice from the priority rules: highest/lowest set bit, or rotating search.
   function automatic logic [1:0] pick(input logic [3:0] pend, input bit ph, input logic [1:0] rp);
      int p;
      int n;
      p = int'(pend);
      n = 0;
`ifdef ENCODER_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++) begin
         n = ph ? (int'(rp) + 4 - k) % 4 : (int'(rp) + k) % 4;
         if (((p >> n) & 1) == 1) return 2'(n);
      end
      return 2'(0);
`else
      if (rp == 2'd3) n = 0;
      if (!ph) p = p & (-p);
      while (p > 1) begin
         p = p >> 1;
         n++;
      end
      return 2'(n);
`endif
   endfunction

   task automatic model_edge();
      bit         ph;
      bit         ld;
      logic [1:0] s;
      logic [3:0] nxt;
      for (int d = 0; d < 2; d++) begin
         ph = (d == 0);
         if (rst) begin
            mp[d] = '0; mo[d] = '0; mv[d] = 1'b0; mr[d] = ph ? 2'd3 : 2'd0;
         end else begin
            ld  = (!mv[d] || out_ready) && (mp[d] != 4'b0000);
            nxt = mp[d];
            if (ld) begin
               s     = pick(mp[d], ph, mr[d]);
               mo[d] = s;
               mv[d] = 1'b1;
               nxt   = nxt & ~(4'b0001 << s);
               mr[d] = ph ? 2'(s - 2'd1) : 2'(s + 2'd1);
            end else if (mv[d] && out_ready) begin
               mv[d] = 1'b0;
            end
            mp[d] = nxt | (ena ? in_ : 4'b0000);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("valid_d%0d", d), {1'b0, dval[d]}, {1'b0, mv[d]});
         chk($sformatf("busy_d%0d", d), {1'b0, dbusy[d]}, {1'b0, (mp[d] != 4'b0000) || mv[d]});
         chk($sformatf("out_d%0d", d), dout[d], mo[d]);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic [3:0] i, input logic rd);
      rst = r; ena = e; in_ = i; out_ready = rd;
      if (!r && dval[0] === 1'b1 && rd) gq0.push_back(int'(dout[0]));
      if (!r && dval[1] === 1'b1 && rd) gq1.push_back(int'(dout[1]));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 4'b0000, 1'b0);
      cyc(1'b1, 1'b0, 4'b0000, 1'b0);
      gq0.delete();
      gq1.delete();
   endtask

   task automatic chk_q(input string tag, input int d, input int exp[$], input bit exact);
      int got[$];
      got = (d == 0) ? gq0 : gq1;
      n_tests++;
      assert (exact ? got.size() == exp.size() : got.size() >= exp.size()) else begin
         n_fail++;
         $error("FAIL %s_count: observed %0d grants expected %0d", tag, got.size(), exp.size());
      end
      for (int k = 0; k < exp.size(); k++) begin
         if (k < got.size()) chk($sformatf("%s_g%0d", tag, k), 2'(got[k]), 2'(exp[k]));
      end
   endtask

   initial begin
      // Idle after reset
      do_reset();
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 4'b0000, 1'b1);
      chk("idle_valid", {1'b0, dval[0]}, 2'd0);
      chk("idle_busy", {1'b0, dbusy[0]}, 2'd0);
      chk("idle_out", dout[0], 2'd0);

      // Single strobe on bit 2
      do_reset();
      cyc(1'b0, 1'b1, 4'b0100, 1'b1);
      chk("single_lat1", {1'b0, dval[0]}, 2'd0);
      cyc(1'b0, 1'b1, 4'b0000, 1'b1);
      chk("single_lat2", {1'b0, dval[0]}, 2'd1);
      chk("single_out", dout[0], 2'd2);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 4'b0000, 1'b1);
      chk_q("single_hi", 0, '{2}, 1'b1);
      chk_q("single_lo", 1, '{2}, 1'b1);

      // Multi-hot 1011 drained back-to-back
      do_reset();
      cyc(1'b0, 1'b1, 4'b1011, 1'b1);
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 4'b0000, 1'b1);
      chk_q("multi_hi", 0, '{3, 1, 0}, 1'b1);
      chk_q("multi_lo", 1, '{0, 1, 3}, 1'b1);

      // Back-pressure hold, then drain with capture disabled
      do_reset();
      cyc(1'b0, 1'b1, 4'b0011, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 4'b1111, 1'b0);
      chk("hold_valid", {1'b0, dval[0]}, 2'd1);
      chk("hold_out", dout[0], 2'd1);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 4'b1111, 1'b1);
      chk_q("hold_hi", 0, '{1, 0}, 1'b1);
      chk_q("hold_lo", 1, '{0, 1}, 1'b1);

      // Set-over-clear collision on the bit being loaded
      do_reset();
      cyc(1'b0, 1'b1, 4'b0011, 1'b1);
      cyc(1'b0, 1'b1, 4'b0010, 1'b1);
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 4'b0000, 1'b1);
`ifdef ENCODER_ROUND_ROBIN_EN
      chk_q("coll_hi", 0, '{1, 0, 1}, 1'b1);
`else
      chk_q("coll_hi", 0, '{1, 1, 0}, 1'b1);
`endif
      chk_q("coll_lo", 1, '{0, 1}, 1'b1);

      // Reset during an outstanding grant
      do_reset();
      cyc(1'b0, 1'b1, 4'b1100, 1'b0);
      cyc(1'b0, 1'b1, 4'b0000, 1'b0);
      chk("pre_rst_valid", {1'b0, dval[0]}, 2'd1);
      cyc(1'b1, 1'b1, 4'b1111, 1'b1);
      chk("rst_valid", {1'b0, dval[0]}, 2'd0);
      chk("rst_busy", {1'b0, dbusy[0]}, 2'd0);
      chk("rst_out", dout[0], 2'd0);
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 4'b0000, 1'b1);
      chk_q("rst_hi", 0, '{}, 1'b1);

      // Continuous all-ones requests
      do_reset();
      for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 4'b1111, 1'b1);
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 4'b0000, 1'b1);
`ifdef ENCODER_ROUND_ROBIN_EN
      chk_q("all_hi", 0, '{3, 2, 1, 0, 3}, 1'b0);
      chk_q("all_lo", 1, '{0, 1, 2, 3, 0}, 1'b0);
`else
      chk_q("all_hi", 0, '{3, 3, 3, 3, 3}, 1'b0);
      chk_q("all_lo", 1, '{0, 0, 0, 0, 0}, 1'b0);
`endif

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 400; k++)
         cyc(1'($urandom_range(39) == 0), 1'($urandom_range(1)),
             4'($urandom_range(15)), 1'($urandom_range(3) != 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
